axi_lite_to_axi_ot: RTL

- Protocol upconverter from an AXI4-Lite slave port to an AXI4 master port.
- Generalises the plain lite-to-full converter with:
  - configurable ID, user, cache and data width;
  - independent outstanding-transaction limits for reads and writes, enforced by counters;
  - status outputs;
  - a sticky protocol-error flag.
- Sits between AXI-Lite peripheral masters (config DMAs, debug modules) and the AXI4 crossbar.

---
 rtl/axi_lite_to_axi_ot.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_to_axi_ot.sv
// -----------------------------------------------------------------------------
// axi_lite_to_axi_ot
//
// Upconverts an AXI4-Lite slave port to an AXI4 master port. Every channel is a
// zero-latency pass-through. New AW/AR requests are held back once the number
// of in-flight writes/reads reaches MaxWrTxns/MaxRdTxns. Counters and a sticky
// protocol-error flag are exported as status.
//
// Ports:
//   clk_i             clock, rising edge
//   rst_ni            asynchronous active-low reset
//   slv_req_i         AXI-Lite request  (AW, W, B-ready, AR, R-ready)
//   slv_resp_o        AXI-Lite response (AW/W/AR-ready, B, R)
//   mst_req_o         AXI4 request
//   mst_resp_i        AXI4 response
//   wr_outstanding_o  writes issued on AW whose B has not been accepted yet
//   rd_outstanding_o  reads issued on AR whose R has not been accepted yet
//   busy_o            either counter nonzero
//   err_o             sticky protocol-error flag, cleared only by reset
//
// The package below supplies default channel structs for the default widths.
// Instances with other widths pass their own struct types.
// -----------------------------------------------------------------------------
package axi_lite_to_axi_ot_pkg;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned IdWidth   = 8;
  localparam int unsigned UserWidth = 8;

  typedef logic [AddrWidth-1:0]   addr_t;
  typedef logic [DataWidth-1:0]   data_t;
  typedef logic [DataWidth/8-1:0] strb_t;
  typedef logic [IdWidth-1:0]     id_t;
  typedef logic [UserWidth-1:0]   user_t;

  typedef struct packed { addr_t addr; logic [2:0] prot; } lite_ax_t;
  typedef struct packed { data_t data; strb_t strb; } lite_w_t;
  typedef struct packed { logic [1:0] resp; } lite_b_t;
  typedef struct packed { data_t data; logic [1:0] resp; } lite_r_t;

  typedef struct packed {
    lite_ax_t aw; logic aw_valid;
    lite_w_t  w;  logic w_valid;
    logic     b_ready;
    lite_ax_t ar; logic ar_valid;
    logic     r_ready;
  } lite_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    lite_b_t b; logic b_valid;
    logic    ar_ready;
    lite_r_t r; logic r_valid;
  } lite_resp_t;

  typedef struct packed {
    id_t id; addr_t addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst;
    logic lock; logic [3:0] cache; logic [2:0] prot; logic [3:0] qos;
    logic [3:0] region; logic [5:0] atop; user_t user;
  } axi_aw_t;

  typedef struct packed {
    id_t id; addr_t addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst;
    logic lock; logic [3:0] cache; logic [2:0] prot; logic [3:0] qos;
    logic [3:0] region; user_t user;
  } axi_ar_t;

  typedef struct packed { data_t data; strb_t strb; logic last; user_t user; } axi_w_t;
  typedef struct packed { id_t id; logic [1:0] resp; user_t user; } axi_b_t;
  typedef struct packed { id_t id; data_t data; logic [1:0] resp; logic last; user_t user; } axi_r_t;

  typedef struct packed {
    axi_aw_t aw; logic aw_valid;
    axi_w_t  w;  logic w_valid;
    logic    b_ready;
    axi_ar_t ar; logic ar_valid;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   w_ready;
    axi_b_t b; logic b_valid;
    logic   ar_ready;
    axi_r_t r; logic r_valid;
  } axi_resp_t;
endpackage

module axi_lite_to_axi_ot #(
  parameter int unsigned AxiAddrWidth = 32,
  parameter int unsigned AxiDataWidth = 32,
  parameter int unsigned AxiIdWidth   = 8,
  parameter int unsigned AxiUserWidth = 8,
  parameter logic [AxiIdWidth-1:0]   AxiId    = '0,
  parameter logic [AxiUserWidth-1:0] AxiUser  = '0,
  parameter logic [3:0]              AxiCache = 4'b0000,
  parameter int unsigned MaxWrTxns = 4,
  parameter int unsigned MaxRdTxns = 4,
  parameter int unsigned CntWidth  =
      $clog2(((MaxWrTxns > MaxRdTxns) ? MaxWrTxns : MaxRdTxns) + 1),
  parameter type lite_req_t  = axi_lite_to_axi_ot_pkg::lite_req_t,
  parameter type lite_resp_t = axi_lite_to_axi_ot_pkg::lite_resp_t,
  parameter type axi_req_t   = axi_lite_to_axi_ot_pkg::axi_req_t,
  parameter type axi_resp_t  = axi_lite_to_axi_ot_pkg::axi_resp_t
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  lite_req_t           slv_req_i,
  output lite_resp_t          slv_resp_o,
  output axi_req_t            mst_req_o,
  input  axi_resp_t           mst_resp_i,
  output logic [CntWidth-1:0] wr_outstanding_o,
  output logic [CntWidth-1:0] rd_outstanding_o,
  output logic                busy_o,
  output logic                err_o
);

  localparam logic [2:0]          AxSize = 3'($clog2(AxiDataWidth / 8));
  localparam logic [CntWidth-1:0] WrMax  = CntWidth'(MaxWrTxns);
  localparam logic [CntWidth-1:0] RdMax  = CntWidth'(MaxRdTxns);

  logic [CntWidth-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic                err_q, err_d;
  logic                wr_full, rd_full;
  logic                aw_hs, b_hs, ar_hs, r_hs;

  // Width-typed copies of the payloads so a struct/parameter mismatch is caught.
  logic [AxiAddrWidth-1:0] aw_addr, ar_addr;
  logic [AxiDataWidth-1:0] w_data, r_data;
  logic                    unused_user;

  assign aw_addr = slv_req_i.aw.addr;
  assign ar_addr = slv_req_i.ar.addr;
  assign w_data  = slv_req_i.w.data;
  assign r_data  = mst_resp_i.r.data;
  assign unused_user = ^{mst_resp_i.b.user, mst_resp_i.r.user};

  // Gate on registered counters only: no combinational response-to-ready path.
  assign wr_full = (wr_cnt_q == WrMax);
  assign rd_full = (rd_cnt_q == RdMax);

  always_comb begin
    mst_req_o  = '0;
    slv_resp_o = '0;

    mst_req_o.aw.id     = AxiId;
    mst_req_o.aw.addr   = aw_addr;
    mst_req_o.aw.len    = 8'd0;
    mst_req_o.aw.size   = AxSize;
    mst_req_o.aw.burst  = 2'b01;
    mst_req_o.aw.lock   = 1'b0;
    mst_req_o.aw.cache  = AxiCache;
    mst_req_o.aw.prot   = slv_req_i.aw.prot;
    mst_req_o.aw.qos    = 4'd0;
    mst_req_o.aw.region = 4'd0;
    mst_req_o.aw.atop   = 6'd0;
    mst_req_o.aw.user   = AxiUser;

    mst_req_o.ar.id     = AxiId;
    mst_req_o.ar.addr   = ar_addr;
    mst_req_o.ar.len    = 8'd0;
    mst_req_o.ar.size   = AxSize;
    mst_req_o.ar.burst  = 2'b01;
    mst_req_o.ar.lock   = 1'b0;
    mst_req_o.ar.cache  = AxiCache;
    mst_req_o.ar.prot   = slv_req_i.ar.prot;
    mst_req_o.ar.qos    = 4'd0;
    mst_req_o.ar.region = 4'd0;
    mst_req_o.ar.user   = AxiUser;

    mst_req_o.w.data = w_data;
    mst_req_o.w.strb = slv_req_i.w.strb;
    mst_req_o.w.last = 1'b1;
    mst_req_o.w.user = AxiUser;

    slv_resp_o.b.resp = mst_resp_i.b.resp;
    slv_resp_o.r.data = r_data;
    slv_resp_o.r.resp = mst_resp_i.r.resp;

    // Handshake signals are forced low while reset is asserted.
    mst_req_o.aw_valid  = rst_ni & slv_req_i.aw_valid & ~wr_full;
    slv_resp_o.aw_ready = rst_ni & mst_resp_i.aw_ready & ~wr_full;
    mst_req_o.ar_valid  = rst_ni & slv_req_i.ar_valid & ~rd_full;
    slv_resp_o.ar_ready = rst_ni & mst_resp_i.ar_ready & ~rd_full;
    mst_req_o.w_valid   = rst_ni & slv_req_i.w_valid;
    slv_resp_o.w_ready  = rst_ni & mst_resp_i.w_ready;
    slv_resp_o.b_valid  = rst_ni & mst_resp_i.b_valid;
    mst_req_o.b_ready   = rst_ni & slv_req_i.b_ready;
    slv_resp_o.r_valid  = rst_ni & mst_resp_i.r_valid;
    mst_req_o.r_ready   = rst_ni & slv_req_i.r_ready;
  end

  assign aw_hs = mst_req_o.aw_valid  & mst_resp_i.aw_ready;
  assign ar_hs = mst_req_o.ar_valid  & mst_resp_i.ar_ready;
  assign b_hs  = slv_resp_o.b_valid  & slv_req_i.b_ready;
  assign r_hs  = slv_resp_o.r_valid  & slv_req_i.r_ready;

  // Increment and decrement together leave the count alone; a lone decrement
  // at zero saturates (that case is flagged as an error instead).
  function automatic logic [CntWidth-1:0] next_cnt(input logic [CntWidth-1:0] cnt,
                                                   input logic inc, input logic dec);
    if (inc && !dec)                 return cnt + 1'b1;
    else if (dec && !inc && cnt != '0) return cnt - 1'b1;
    else                             return cnt;
  endfunction

  always_comb begin
    wr_cnt_d = next_cnt(wr_cnt_q, aw_hs, b_hs);
    rd_cnt_d = next_cnt(rd_cnt_q, ar_hs, r_hs);
    err_d    = err_q
             | (b_hs & ((wr_cnt_q == '0) | (mst_resp_i.b.id != AxiId)))
             | (r_hs & (~mst_resp_i.r.last | (rd_cnt_q == '0) | (mst_resp_i.r.id != AxiId)));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      err_q    <= err_d;
    end
  end

  assign wr_outstanding_o = wr_cnt_q;
  assign rd_outstanding_o = rd_cnt_q;
  assign busy_o           = (wr_cnt_q != '0) | (rd_cnt_q != '0);
  assign err_o            = err_q;

`ifndef SYNTHESIS
  a_aw_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mst_req_o.aw_valid && !mst_resp_i.aw_ready |=> mst_req_o.aw_valid && $stable(mst_req_o.aw));
  a_w_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mst_req_o.w_valid && !mst_resp_i.w_ready |=> mst_req_o.w_valid && $stable(mst_req_o.w));
  a_ar_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mst_req_o.ar_valid && !mst_resp_i.ar_ready |=> mst_req_o.ar_valid && $stable(mst_req_o.ar));
  a_wr_max: assert property (@(posedge clk_i) disable iff (!rst_ni) wr_cnt_q <= WrMax);
  a_rd_max: assert property (@(posedge clk_i) disable iff (!rst_ni) rd_cnt_q <= RdMax);
`endif

endmodule
